bomb_slot_arbiter: RTL

- Shares a fixed pool of bomb slots between two players in versus/story gameplay.
- Filters player drop requests, arbitrates round-robin on contention, and allocates slots.
- Runs each slot's fuse and blast timers from the global one-second pulse.
- Exports per-slot state and grid position to the bomb/explosion drawing objects and collision logic. Active only while the game state machine asserts game_on.

---
 rtl/bomb_slot_arbiter.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/bomb_slot_arbiter.sv
// Shared bomb-slot pool for two players: request filtering, round-robin arbitration,
// per-slot fuse/blast timers. Define CHAIN_REACTION_EN to let blasts detonate nearby fuses.
module bomb_slot_arbiter #(
    parameter int NUM_SLOTS      = 4,
    parameter int MAX_PER_PLAYER = 2,
    parameter int FUSE_SEC       = 3,
    parameter int BLAST_SEC      = 1,
    parameter int BLAST_RADIUS   = 2
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   game_on,
    input  logic                   one_sec_pulse,
    input  logic                   p1_drop_req,
    input  logic [4:0]             p1_col,
    input  logic [3:0]             p1_row,
    input  logic                   p2_drop_req,
    input  logic [4:0]             p2_col,
    input  logic [3:0]             p2_row,
    output logic                   p1_grant,
    output logic                   p2_grant,
    output logic                   p1_deny,
    output logic                   p2_deny,
    output logic [NUM_SLOTS-1:0]   slot_fuse,
    output logic [NUM_SLOTS-1:0]   slot_blast,
    output logic [NUM_SLOTS-1:0]   slot_owner,
    output logic [NUM_SLOTS*5-1:0] slot_col,
    output logic [NUM_SLOTS*4-1:0] slot_row,
    output logic                   explode_pulse
);

    typedef enum logic [1:0] {ST_FREE, ST_FUSE, ST_BLAST} slot_state_e;

    localparam logic [3:0] MAX_CNT  = 4'(MAX_PER_PLAYER);
    localparam logic [2:0] FUSE_LD  = 3'(FUSE_SEC);
    localparam logic [2:0] BLAST_LD = 3'(BLAST_SEC);
    localparam logic [4:0] RADIUS   = 5'(BLAST_RADIUS);
`ifdef CHAIN_REACTION_EN
    localparam logic CHAIN_ON = 1'b1;
`else
    localparam logic CHAIN_ON = 1'b0;
`endif

    slot_state_e          state_q [NUM_SLOTS];
    slot_state_e          state_d [NUM_SLOTS];
    logic [2:0]           cnt_q   [NUM_SLOTS];
    logic [2:0]           cnt_d   [NUM_SLOTS];
    logic [4:0]           col_q   [NUM_SLOTS];
    logic [4:0]           col_d   [NUM_SLOTS];
    logic [3:0]           row_q   [NUM_SLOTS];
    logic [3:0]           row_d   [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] owner_q, owner_d;

    logic p1_flag_q, p1_flag_d, p2_flag_q, p2_flag_d;
    logic ptr_q, ptr_d;
    logic p1_grant_q, p1_grant_d, p2_grant_q, p2_grant_d;
    logic p1_deny_q, p1_deny_d, p2_deny_q, p2_deny_d;
    logic explode_q, explode_d;

    logic [3:0]           p1_cnt, p2_cnt;
    logic                 p1_hit, p2_hit;
    logic                 found1, found2;
    logic [NUM_SLOTS-1:0] first_oh, second_oh;
    logic [NUM_SLOTS-1:0] chain_hit;
    logic                 p1_valid, p2_valid, p1_ok, p2_ok, same_cell;
    logic                 g1, g2, d1, d2;
    logic [NUM_SLOTS-1:0] p1_mask, p2_mask;

    function automatic logic near(input logic [4:0] a, input logic [4:0] b);
        return ((a >= b) ? (a - b) : (b - a)) <= RADIUS;
    endfunction

    // Occupancy: per-player counts, cell collisions and the two lowest free slots.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        p1_cnt    = '0;
        p2_cnt    = '0;
        p1_hit    = 1'b0;
        p2_hit    = 1'b0;
        found1    = 1'b0;
        found2    = 1'b0;
        first_oh  = '0;
        second_oh = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (state_q[i] != ST_FREE) begin
                if (owner_q[i]) p2_cnt = p2_cnt + 4'd1;
                else            p1_cnt = p1_cnt + 4'd1;
                if (col_q[i] == p1_col && row_q[i] == p1_row) p1_hit = 1'b1;
                if (col_q[i] == p2_col && row_q[i] == p2_row) p2_hit = 1'b1;
            end else if (!found1) begin
                first_oh[i] = 1'b1;
                found1      = 1'b1;
            end else if (!found2) begin
                second_oh[i] = 1'b1;
                found2       = 1'b1;
            end
        end
    end

    always_comb begin
        chain_hit = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            for (int j = 0; j < NUM_SLOTS; j++) begin
                if (CHAIN_ON && state_q[i] == ST_FUSE && state_q[j] == ST_BLAST &&
                    ((row_q[i] == row_q[j] && near(col_q[i], col_q[j])) ||
                     (col_q[i] == col_q[j] && near({1'b0, row_q[i]}, {1'b0, row_q[j]}))))
                    chain_hit[i] = 1'b1;
            end
        end
    end

    // Arbitration; the pointer only moves when one player has to lose.
    always_comb begin
        p1_valid  = game_on && p1_drop_req && !p1_flag_q;
        p2_valid  = game_on && p2_drop_req && !p2_flag_q;
        p1_ok     = p1_valid && (p1_cnt < MAX_CNT) && !p1_hit;
        p2_ok     = p2_valid && (p2_cnt < MAX_CNT) && !p2_hit;
        same_cell = (p1_col == p2_col) && (p1_row == p2_row);
        g1        = 1'b0;
        g2        = 1'b0;
        d1        = 1'b0;
        d2        = 1'b0;
        ptr_d     = ptr_q;
        if (p1_ok && p2_ok) begin
            if (!found1) begin
                d1 = 1'b1;
                d2 = 1'b1;
            end else if (same_cell || !found2) begin
                if (!ptr_q) begin
                    g1 = 1'b1;
                    d2 = 1'b1;
                end else begin
                    g2 = 1'b1;
                    d1 = 1'b1;
                end
                ptr_d = !ptr_q;
            end else begin
                g1 = 1'b1;
                g2 = 1'b1;
            end
        end else begin
            if (p1_ok) begin
                g1 = found1;
                d1 = !found1;
            end
            if (p2_ok) begin
                g2 = found1;
                d2 = !found1;
            end
        end
        if (p1_valid && !p1_ok) d1 = 1'b1;
        if (p2_valid && !p2_ok) d2 = 1'b1;
        if (!game_on) ptr_d = 1'b0;

        p1_mask = g1 ? ((g2 && ptr_q)  ? second_oh : first_oh) : '0;
        p2_mask = g2 ? ((g1 && !ptr_q) ? second_oh : first_oh) : '0;

        p1_flag_d  = p1_drop_req;
        p2_flag_d  = p2_drop_req;
        p1_grant_d = g1;
        p2_grant_d = g2;
        p1_deny_d  = d1;
        p2_deny_d  = d2;
    end

    // Per-slot FSM and timers.
    always_comb begin
        explode_d = 1'b0;
        owner_d   = owner_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            col_d[i]   = col_q[i];
            row_d[i]   = row_q[i];
            if (!game_on) begin
                state_d[i] = ST_FREE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    ST_FREE: begin
                        if (p1_mask[i] || p2_mask[i]) begin
                            state_d[i] = ST_FUSE;
                            cnt_d[i]   = FUSE_LD;
                            owner_d[i] = p2_mask[i];
                            col_d[i]   = p2_mask[i] ? p2_col : p1_col;
                            row_d[i]   = p2_mask[i] ? p2_row : p1_row;
                        end
                    end
                    ST_FUSE: begin
                        if (chain_hit[i] || (one_sec_pulse && cnt_q[i] == 3'd1)) begin
                            state_d[i] = ST_BLAST;
                            cnt_d[i]   = BLAST_LD;
                            explode_d  = 1'b1;
                        end else if (one_sec_pulse) begin
                            cnt_d[i] = cnt_q[i] - 3'd1;
                        end
                    end
                    ST_BLAST: begin
                        if (one_sec_pulse && cnt_q[i] == 3'd1) begin
                            state_d[i] = ST_FREE;
                            cnt_d[i]   = '0;
                        end else if (one_sec_pulse) begin
                            cnt_d[i] = cnt_q[i] - 3'd1;
                        end
                    end
                    default: begin
                        state_d[i] = ST_FREE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // NOTE: the slot table is reset too, since its state and position drive outputs directly.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_q[i] <= ST_FREE;
                cnt_q[i]   <= '0;
                col_q[i]   <= '0;
                row_q[i]   <= '0;
            end
            owner_q    <= '0;
            p1_flag_q  <= 1'b0;
            p2_flag_q  <= 1'b0;
            ptr_q      <= 1'b0;
            p1_grant_q <= 1'b0;
            p2_grant_q <= 1'b0;
            p1_deny_q  <= 1'b0;
            p2_deny_q  <= 1'b0;
            explode_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                col_q[i]   <= col_d[i];
                row_q[i]   <= row_d[i];
            end
            owner_q    <= owner_d;
            p1_flag_q  <= p1_flag_d;
            p2_flag_q  <= p2_flag_d;
            ptr_q      <= ptr_d;
            p1_grant_q <= p1_grant_d;
            p2_grant_q <= p2_grant_d;
            p1_deny_q  <= p1_deny_d;
            p2_deny_q  <= p2_deny_d;
            explode_q  <= explode_d;
        end
    end

    always_comb begin
        p1_grant      = p1_grant_q;
        p2_grant      = p2_grant_q;
        p1_deny       = p1_deny_q;
        p2_deny       = p2_deny_q;
        explode_pulse = explode_q;
        slot_owner    = owner_q;
        slot_fuse     = '0;
        slot_blast    = '0;
        slot_col      = '0;
        slot_row      = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_fuse[i]       = (state_q[i] == ST_FUSE);
            slot_blast[i]      = (state_q[i] == ST_BLAST);
            slot_col[i*5 +: 5] = col_q[i];
            slot_row[i*4 +: 4] = row_q[i];
        end
    end

endmodule
